// File: rtl/axis_stream_buffer.sv
// Single-clock AXI4-Stream FIFO: circular buffer of {tlast, tstrb, tdata} beats
// with first-word-fall-through master side and full-based upstream backpressure.
module axis_stream_buffer #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_DEPTH              = 16
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_tstrb,
  input  logic                                S_AXIS_tlast,
  input  logic                                S_AXIS_tvalid,
  output logic                                S_AXIS_tready,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_tstrb,
  output logic                                M_AXIS_tlast,
  output logic                                M_AXIS_tvalid,
  input  logic                                M_AXIS_tready,
  output logic [$clog2(C_DEPTH):0]            occupancy
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int AW = $clog2(C_DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         mem_q [C_DEPTH];
  beat_t         beat_in;
  beat_t         head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          full, empty, push, pop;

  always_comb begin
    full    = (occ_q == OW'(C_DEPTH));
    empty   = (occ_q == '0);
    // Readiness depends only on stored state, so a pop never frees a slot
    // for a push in the same cycle.
    S_AXIS_tready = !full && !areset;
    M_AXIS_tvalid = !empty;
    push    = S_AXIS_tvalid && S_AXIS_tready;
    pop     = M_AXIS_tvalid && M_AXIS_tready;
    beat_in = '{last: S_AXIS_tlast, strb: S_AXIS_tstrb, data: S_AXIS_tdata};
    // Power-of-two depth: pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    head = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign M_AXIS_tdata = head.data;
  assign M_AXIS_tstrb = head.strb;
  assign M_AXIS_tlast = head.last;
  assign occupancy    = occ_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is left uncleared on reset; occupancy alone defines validity.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= beat_in;
  end

endmodule

// File: tb/tb_axis_stream_buffer.sv
// Directed and scoreboard-based checks of axis_stream_buffer (32-bit, depth 16).
module tb_axis_stream_buffer;
  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast, m_tvalid, m_tready;
  logic [4:0]  occ;
  int          n_cmp = 0;
  int          n_err = 0;

  axis_stream_buffer #(.C_S_AXIS_TDATA_WIDTH(32), .C_DEPTH(16)) dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tstrb(s_tstrb), .S_AXIS_tlast(s_tlast),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tstrb(m_tstrb), .M_AXIS_tlast(m_tlast),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .occupancy(occ)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!m_tvalid) break;
      tick();
    end
    n_cmp++; if (m_tvalid !== 1'b0 || occ !== 5'd0) begin n_err++;
      $display("FAIL drain: got valid=%b occ=%0d want valid=0 occ=0", m_tvalid, occ); end
  endtask

  task automatic test_reset();
    areset = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h1234_5678; s_tstrb = 4'hF;
    s_tlast = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", s_tready); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid: got %b want 0", m_tvalid); end
      n_cmp++; if (occ !== 5'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occ); end
    end
    n_cmp++; if ({m_tlast, m_tstrb, m_tdata} !== 37'd0) begin n_err++;
      $display("FAIL rst_mdata: got %h want 0", {m_tlast, m_tstrb, m_tdata}); end
    areset = 1'b0; s_tvalid = 1'b0;
    tick();
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_release_tready: got %b want 1", s_tready); end
    n_cmp++; if (occ !== 5'd0) begin n_err++; $display("FAIL rst_release_occ: got %0d want 0", occ); end
  endtask

  task automatic test_streaming();
    s_tdata = 32'habcdef01; s_tstrb = 4'hF; s_tlast = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, m_tvalid); end
      n_cmp++; if (m_tdata !== 32'habcdef01) begin n_err++; $display("FAIL stream_data[%0d]: got %h want abcdef01", i, m_tdata); end
      n_cmp++; if (occ !== 5'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ); end
    end
    s_tvalid = 1'b0;
    tick();
    n_cmp++; if (m_tvalid !== 1'b0 || occ !== 5'd0) begin n_err++;
      $display("FAIL stream_empty: got valid=%b occ=%0d want 0/0", m_tvalid, occ); end
    n_cmp++; if (m_tdata !== 32'd0) begin n_err++; $display("FAIL stream_empty_data: got %h want 0", m_tdata); end
  endtask

  task automatic test_fill();
    int  acc;
    int  d;
    logic hs;
    acc = 0; d = 0;
    m_tready = 1'b0; s_tvalid = 1'b1; s_tstrb = 4'hF; s_tlast = 1'b0; s_tdata = 32'd0;
    for (int i = 0; i < 20; i++) begin
      hs = s_tvalid && s_tready;
      tick();
      if (hs) begin acc++; d++; s_tdata = 32'(d); end
    end
    n_cmp++; if (acc != 16) begin n_err++; $display("FAIL fill_accepted: got %0d want 16", acc); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL fill_tready: got %b want 0", s_tready); end
    n_cmp++; if (occ !== 5'd16) begin n_err++; $display("FAIL fill_occ: got %0d want 16", occ); end
    m_tready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL fill_out_valid[%0d]: got %b want 1", k, m_tvalid); end
      n_cmp++; if (m_tdata !== 32'(k)) begin n_err++; $display("FAIL fill_out_data[%0d]: got %h want %h", k, m_tdata, 32'(k)); end
      hs = s_tvalid && s_tready;
      tick();
      if (hs) begin d++; s_tdata = 32'(d); end
      if (k == 0) begin
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL fill_tready_return: got %b want 1", s_tready); end
      end
    end
    drain();
  endtask

  task automatic test_sideband();
    logic [3:0] sb [4];
    sb[0] = 4'hF; sb[1] = 4'hF; sb[2] = 4'hF; sb[3] = 4'h3;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 32'hA000 + 32'(i); s_tstrb = sb[i]; s_tlast = (i == 3); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_cmp++; if (occ !== 5'd4) begin n_err++; $display("FAIL sb_occ: got %0d want 4", occ); end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (m_tdata !== 32'hA000 + 32'(i)) begin n_err++; $display("FAIL sb_data[%0d]: got %h want %h", i, m_tdata, 32'hA000 + 32'(i)); end
      n_cmp++; if (m_tstrb !== sb[i]) begin n_err++; $display("FAIL sb_strb[%0d]: got %h want %h", i, m_tstrb, sb[i]); end
      n_cmp++; if (m_tlast !== (i == 3)) begin n_err++; $display("FAIL sb_last[%0d]: got %b want %b", i, m_tlast, (i == 3)); end
      tick();
    end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL sb_empty: got %b want 0", m_tvalid); end
  endtask

  task automatic test_random();
    logic [36:0] q [$];
    logic [36:0] exp_b, prev_out;
    logic        prev_stall, s_hs, m_hs, s_hs_prev;
    int          popped, cyc;
    popped = 0; cyc = 0; prev_stall = 1'b0; s_hs_prev = 1'b0; prev_out = '0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    while (popped < 1200 && cyc < 20000) begin
      if (!s_tvalid || s_hs_prev) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = $urandom;
        s_tstrb  = 4'($urandom);
        s_tlast  = ($urandom_range(0, 7) == 0);
      end
      m_tready = cyc[8] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (s_tready !== (q.size() != 16)) begin n_err++;
        $display("FAIL rnd_tready[%0d]: got %b want %b", cyc, s_tready, (q.size() != 16)); end
      n_cmp++; if (m_tvalid !== (q.size() != 0)) begin n_err++;
        $display("FAIL rnd_mvalid[%0d]: got %b want %b", cyc, m_tvalid, (q.size() != 0)); end
      if (prev_stall) begin
        n_cmp++; if ({m_tlast, m_tstrb, m_tdata} !== prev_out) begin n_err++;
          $display("FAIL rnd_stable[%0d]: got %h want %h", cyc, {m_tlast, m_tstrb, m_tdata}, prev_out); end
      end
      s_hs = s_tvalid && s_tready;
      m_hs = m_tvalid && m_tready;
      if (m_hs) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_underflow[%0d]: got beat want none", cyc); end
        else begin
          exp_b = q.pop_front();
          if ({m_tlast, m_tstrb, m_tdata} !== exp_b) begin n_err++;
            $display("FAIL rnd_beat[%0d]: got %h want %h", popped, {m_tlast, m_tstrb, m_tdata}, exp_b); end
        end
        popped++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tstrb, m_tdata};
      if (s_hs) q.push_back({s_tlast, s_tstrb, s_tdata});
      s_hs_prev = s_hs;
      tick();
      cyc++;
      n_cmp++; if (occ !== 5'(q.size())) begin n_err++;
        $display("FAIL rnd_occ[%0d]: got %0d want %0d", cyc, occ, q.size()); end
    end
    n_cmp++; if (popped < 1200) begin n_err++; $display("FAIL rnd_timeout: got %0d beats want 1200", popped); end
    drain();
  endtask

  task automatic test_midreset();
    m_tready = 1'b0; s_tstrb = 4'hF; s_tlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 32'h100 + 32'(i); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    n_cmp++; if (occ !== 5'd10) begin n_err++; $display("FAIL mid_occ_pre: got %0d want 10", occ); end
    areset = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL mid_tready_rst: got %b want 0", s_tready); end
    tick();
    n_cmp++; if (occ !== 5'd0) begin n_err++; $display("FAIL mid_occ_post: got %0d want 0", occ); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_mvalid_post: got %b want 0", m_tvalid); end
    areset = 1'b0;
    #1;
    s_tdata = 32'hdeadbeef; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (occ !== 5'd1) begin n_err++; $display("FAIL mid_occ_new: got %0d want 1", occ); end
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hdeadbeef) begin n_err++;
      $display("FAIL mid_next_beat: got valid=%b data=%h want 1/deadbeef", m_tvalid, m_tdata); end
    drain();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_sideband();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
